// File: rtl/synth_pkg.sv
// Shared types and constants for the synth output path, including the
// DAC frame layout used by the SPI transmitter.
package synth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    GAP
  } dac_state_e;

  localparam int         DAC_FRAME_BITS = 24;
  localparam int         DAC_DATA_BITS  = 16;
  localparam logic [7:0] DAC_COMMAND    = 8'h30;

  // Offset binary is two's complement with the sign bit inverted.
  function automatic logic [DAC_DATA_BITS-1:0] dac_encode(
    input logic [DAC_DATA_BITS-1:0] sample,
    input bit                       offset_binary
  );
    return offset_binary ? (sample ^ 16'h8000) : sample;
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick for the SPI clock: one tick every CLOCK_DIV cycles while
// enabled, restarted from zero whenever a frame starts.
module spi_tick_gen #(
  parameter int CLOCK_DIV = 2
) (
  input  logic i_Clock,
  input  logic i_Reset_n,
  input  logic i_Enable,
  input  logic i_Clear,
  output logic o_Tick
);

  localparam int CW = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLOCK_DIV - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      count <= '0;
    end else if (i_Clear || !i_Enable || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign o_Tick = i_Enable && (count == LAST);

endmodule

// File: rtl/dac_spi_transmitter.sv
// Serialises synth samples to an SPI DAC as {command, data} frames (mode 0),
// with a one-deep pending buffer and a sticky overrun flag.
module dac_spi_transmitter
  import synth_pkg::*;
#(
  parameter int         CLOCK_DIV     = 2,
  parameter int         CS_GAP        = 4,
  parameter logic [7:0] COMMAND       = DAC_COMMAND,
  parameter bit         OFFSET_BINARY = 1'b1
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset_n,
  input  logic                     i_SampleReady,
  input  logic [DAC_DATA_BITS-1:0] i_Sample,
  input  logic                     i_ClearOverrun,
  output logic                     o_SpiCs_n,
  output logic                     o_SpiClock,
  output logic                     o_SpiMosi,
  output logic                     o_Busy,
  output logic                     o_FrameDone,
  output logic                     o_Overrun
);

  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  dac_state_e                 state;
  logic [DAC_FRAME_BITS-2:0]  shift_reg;   // bits still to send after the one on MOSI
  logic [4:0]                 bit_cnt;
  logic [GW-1:0]              gap_cnt;
  logic [DAC_DATA_BITS-1:0]   pending;
  logic                       pend_valid;
  logic                       tick;
  logic                       start;
  logic [DAC_FRAME_BITS-1:0]  load_frame;

  // The pending sample always takes precedence over a fresh strobe in IDLE.
  assign start      = (state == IDLE) && (pend_valid || i_SampleReady);
  assign load_frame = {COMMAND, dac_encode(pend_valid ? pending : i_Sample, OFFSET_BINARY)};

  spi_tick_gen #(
    .CLOCK_DIV (CLOCK_DIV)
  ) u_tick_gen (
    .i_Clock   (i_Clock),
    .i_Reset_n (i_Reset_n),
    .i_Enable  (state == SHIFT || state == HOLD),
    .i_Clear   (start),
    .o_Tick    (tick)
  );

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      // NOTE: the pending buffer is a single register, not a memory, so it is
      // cleared with everything else and no stale sample survives reset.
      pending     <= '0;
      pend_valid  <= 1'b0;
      o_SpiCs_n   <= 1'b1;
      o_SpiClock  <= 1'b0;
      o_SpiMosi   <= 1'b0;
      o_Busy      <= 1'b0;
      o_FrameDone <= 1'b0;
      o_Overrun   <= 1'b0;
    end else begin
      o_FrameDone <= 1'b0;
      if (i_ClearOverrun) o_Overrun <= 1'b0;

      unique case (state)
        IDLE: begin
          o_Busy <= pend_valid || i_SampleReady;
          if (start) begin
            state      <= SHIFT;
            shift_reg  <= load_frame[DAC_FRAME_BITS-2:0];
            o_SpiMosi  <= load_frame[DAC_FRAME_BITS-1];
            o_SpiCs_n  <= 1'b0;
            o_SpiClock <= 1'b0;
            bit_cnt    <= 5'(DAC_FRAME_BITS - 1);
          end
          // Strobe racing a pending send becomes the next pending sample.
          if (pend_valid) begin
            if (i_SampleReady) pending <= i_Sample;
            else               pend_valid <= 1'b0;
          end
        end

        SHIFT: begin
          o_Busy <= 1'b1;
          if (tick) begin
            if (!o_SpiClock) begin
              o_SpiClock <= 1'b1;
            end else begin
              o_SpiClock <= 1'b0;
              if (bit_cnt == '0) begin
                state <= HOLD;
              end else begin
                bit_cnt   <= bit_cnt - 1'b1;
                o_SpiMosi <= shift_reg[DAC_FRAME_BITS-2];
                shift_reg <= shift_reg << 1;
              end
            end
          end
        end

        HOLD: begin
          o_Busy <= 1'b1;
          if (tick) begin
            state       <= GAP;
            o_SpiCs_n   <= 1'b1;
            o_FrameDone <= 1'b1;
            gap_cnt     <= GW'(CS_GAP - 1);
          end
        end

        GAP: begin
          if (gap_cnt == '0) begin
            state  <= IDLE;
            o_Busy <= pend_valid || i_SampleReady;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
            o_Busy  <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase

      // Outside IDLE every strobe lands in the pending buffer; newest wins.
      if (i_SampleReady && state != IDLE) begin
        pending    <= i_Sample;
        pend_valid <= 1'b1;
        if (pend_valid) o_Overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dac_spi_transmitter.sv
// Directed bench for dac_spi_transmitter: default, raw-binary and fast
// (CLOCK_DIV=1, CS_GAP=1) instances share stimulus; each test observes one.
module tb_dac_spi_transmitter;

  logic        clk;
  logic        rst_n;
  logic        ready;
  logic [15:0] sample;
  logic        clr;
  logic [2:0]  cs_n, sck, mosi, busy, fdone, ovr;

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dac_spi_transmitter u_def (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_SampleReady(ready), .i_Sample(sample),
    .i_ClearOverrun(clr), .o_SpiCs_n(cs_n[0]), .o_SpiClock(sck[0]), .o_SpiMosi(mosi[0]),
    .o_Busy(busy[0]), .o_FrameDone(fdone[0]), .o_Overrun(ovr[0]));

  dac_spi_transmitter #(.OFFSET_BINARY(1'b0)) u_raw (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_SampleReady(ready), .i_Sample(sample),
    .i_ClearOverrun(clr), .o_SpiCs_n(cs_n[1]), .o_SpiClock(sck[1]), .o_SpiMosi(mosi[1]),
    .o_Busy(busy[1]), .o_FrameDone(fdone[1]), .o_Overrun(ovr[1]));

  dac_spi_transmitter #(.CLOCK_DIV(1), .CS_GAP(1)) u_fast (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_SampleReady(ready), .i_Sample(sample),
    .i_ClearOverrun(clr), .o_SpiCs_n(cs_n[2]), .o_SpiClock(sck[2]), .o_SpiMosi(mosi[2]),
    .o_Busy(busy[2]), .o_FrameDone(fdone[2]), .o_Overrun(ovr[2]));

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One-cycle strobe; returns on the following negedge, after the DUT sampled it.
  task automatic strobe(input logic [15:0] s);
    ready  = 1'b1;
    sample = s;
    @(negedge clk);
    ready  = 1'b0;
  endtask

  // Waits for CS_n low, then records MOSI at every SCLK rise until CS_n rises.
  task automatic capture(input int sel, output logic [23:0] data, output int low,
                         output int rises, output int waited, output logic fd,
                         output bit timeout);
    logic prev;
    data = '0; low = 0; rises = 0; waited = 0; fd = 1'b0; timeout = 1'b0; prev = 1'b0;
    while (cs_n[sel] && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    while (!cs_n[sel] && low < 200) begin
      low++;
      if (sck[sel] && !prev) begin
        data = {data[22:0], mosi[sel]};
        rises++;
      end
      prev = sck[sel];
      @(negedge clk);
    end
    timeout = cs_n[sel] ? 1'b0 : 1'b1;
    if (waited >= 400) timeout = 1'b1;
    fd = fdone[sel];
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (cs_n !== 3'b111) begin bad++; $display("FAIL reset_cs got=%b exp=111", cs_n); end
    total++; if (sck !== 3'b000) begin bad++; $display("FAIL reset_sclk got=%b exp=000", sck); end
    total++; if (mosi !== 3'b000) begin bad++; $display("FAIL reset_mosi got=%b exp=000", mosi); end
    total++; if ({busy, fdone, ovr} !== 9'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0", {busy, fdone, ovr}); end
  endtask

  task automatic test_single_frame();
    logic [23:0] d; int low, rises, waited; logic fd; bit to;
    do_reset();
    strobe(16'h1234);
    total++; if (cs_n[0] !== 1'b0) begin bad++; $display("FAIL cs_latency got=%b exp=0", cs_n[0]); end
    total++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL busy_set got=%b exp=1", busy[0]); end
    capture(0, d, low, rises, waited, fd, to);
    total++; if (to) begin bad++; $display("FAIL single_timeout got=1 exp=0"); end
    total++; if (d !== 24'h309234) begin bad++; $display("FAIL single_data got=%h exp=309234", d); end
    total++; if (low !== 98) begin bad++; $display("FAIL single_cs_low got=%0d exp=98", low); end
    total++; if (rises !== 24) begin bad++; $display("FAIL single_rises got=%0d exp=24", rises); end
    total++; if (fd !== 1'b1) begin bad++; $display("FAIL single_done got=%b exp=1", fd); end
    @(negedge clk);
    total++; if (fdone[0] !== 1'b0) begin bad++; $display("FAIL done_one_cycle got=%b exp=0", fdone[0]); end
    repeat (6) @(negedge clk);
    total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL busy_clear got=%b exp=0", busy[0]); end
  endtask

  task automatic test_encoding();
    logic [23:0] d; int low, rises, waited; logic fd; bit to;
    do_reset();
    strobe(16'h8000);
    capture(1, d, low, rises, waited, fd, to);
    total++; if (to || d !== 24'h308000) begin bad++; $display("FAIL raw_8000 got=%h exp=308000 to=%b", d, to); end
    do_reset();
    strobe(16'hFFFF);
    capture(0, d, low, rises, waited, fd, to);
    total++; if (to || d !== 24'h307FFF) begin bad++; $display("FAIL offset_ffff got=%h exp=307fff to=%b", d, to); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] d1, d2; int l1, r1, w1, l2, r2, w2; logic f1, f2; bit t1, t2;
    do_reset();
    strobe(16'h0001);
    fork
      capture(0, d1, l1, r1, w1, f1, t1);
      begin repeat (9) @(negedge clk); strobe(16'h0002); end
    join
    capture(0, d2, l2, r2, w2, f2, t2);
    total++; if (t1 || d1 !== 24'h308001) begin bad++; $display("FAIL b2b_first got=%h exp=308001", d1); end
    total++; if (t2 || d2 !== 24'h308002) begin bad++; $display("FAIL b2b_second got=%h exp=308002", d2); end
    total++; if (w2 !== 5) begin bad++; $display("FAIL b2b_gap got=%0d exp=5", w2); end
    total++; if (ovr[0] !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%b exp=0", ovr[0]); end
  endtask

  task automatic test_overrun();
    logic [23:0] d1, d2; int l1, r1, w1, l2, r2, w2; logic f1, f2; bit t1, t2;
    do_reset();
    strobe(16'hAAAA);
    fork
      capture(0, d1, l1, r1, w1, f1, t1);
      begin
        repeat (5) @(negedge clk); strobe(16'hBBBB);
        repeat (5) @(negedge clk); strobe(16'hCCCC);
      end
    join
    capture(0, d2, l2, r2, w2, f2, t2);
    total++; if (t1 || d1 !== 24'h302AAA) begin bad++; $display("FAIL ovr_first got=%h exp=302aaa", d1); end
    total++; if (t2 || d2 !== 24'h304CCC) begin bad++; $display("FAIL ovr_second got=%h exp=304ccc", d2); end
    total++; if (ovr[0] !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", ovr[0]); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    total++; if (ovr[0] !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", ovr[0]); end
  endtask

  task automatic test_reset_mid_frame();
    logic [23:0] d; int low, rises, waited, n, seen; logic fd, prev; bit to;
    do_reset();
    strobe(16'h5555);
    seen = 0; n = 0; prev = 1'b0;
    while (seen < 10 && n < 300) begin
      @(negedge clk);
      n++;
      if (sck[0] && !prev) seen++;
      prev = sck[0];
    end
    total++; if (seen !== 10) begin bad++; $display("FAIL midreset_rises got=%0d exp=10", seen); end
    rst_n = 1'b0;
    #1;
    total++; if ({cs_n[0], sck[0], busy[0]} !== 3'b100) begin bad++; $display("FAIL midreset_outputs got=%b exp=100", {cs_n[0], sck[0], busy[0]}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    strobe(16'h0F0F);
    capture(0, d, low, rises, waited, fd, to);
    total++; if (to || d !== 24'h308F0F || rises !== 24) begin bad++; $display("FAIL midreset_frame got=%h/%0d exp=308f0f/24", d, rises); end
  endtask

  task automatic test_fast_divider();
    logic [23:0] d; int low, rises, waited; logic fd; bit to;
    do_reset();
    strobe(16'h1234);
    capture(2, d, low, rises, waited, fd, to);
    total++; if (to || d !== 24'h309234) begin bad++; $display("FAIL fast_data got=%h exp=309234", d); end
    total++; if (low !== 49) begin bad++; $display("FAIL fast_cs_low got=%0d exp=49", low); end
    total++; if (rises !== 24) begin bad++; $display("FAIL fast_rises got=%0d exp=24", rises); end
  endtask

  initial begin
    rst_n = 1'b1; ready = 1'b0; sample = '0; clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_encoding();
    test_back_to_back();
    test_overrun();
    test_reset_mid_frame();
    test_fast_divider();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
